// File: rtl/reed_solomon_decoder_pkg.sv
// Shared types and constants for the Reed-Solomon decoder scheduling logic.
package reed_solomon_decoder_pkg;

    localparam int          RS_CW_LEN        = 255;
    localparam int          RS_MSG_LEN       = 223;
    localparam logic [31:0] HC_CONTROL_START = 32'h0000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_GAP,
        S_STALL,
        S_DRAIN,
        S_DONE
    } t_sched_state;

endpackage

// File: rtl/reed_solomon_decoder_out_tracker.sv
// Counts decoded bytes returned by the core, tracks completed codewords and
// forwards accepted bytes to the write-side packer.
module reed_solomon_decoder_out_tracker
    import reed_solomon_decoder_pkg::*;
#(
    parameter int MSG_LEN = RS_MSG_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid_i,
    input  logic [7:0]  dec_data_i,
    input  logic [31:0] cw_started_i,
    output logic        wr_valid_o,
    output logic [7:0]  wr_data_o,
    output logic [31:0] cw_decoded_o,
    output logic        err_overflow_o
);

    localparam int OUT_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic [OUT_W-1:0] out_cnt_q;
    logic [31:0]      cw_decoded_q;
    logic             err_overflow_q;
    logic             wr_valid_q;
    logic [7:0]       wr_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt_q      <= '0;
            cw_decoded_q   <= '0;
            err_overflow_q <= 1'b0;
            wr_valid_q     <= 1'b0;
            wr_data_q      <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            if (dec_valid_i) begin
                // Nothing outstanding in the core: the byte cannot belong to any codeword.
                if (cw_decoded_q == cw_started_i) begin
                    err_overflow_q <= 1'b1;
                end else begin
                    wr_valid_q <= 1'b1;
                    wr_data_q  <= dec_data_i;
                    if (out_cnt_q == OUT_W'(MSG_LEN - 1)) begin
                        out_cnt_q    <= '0;
                        cw_decoded_q <= cw_decoded_q + 32'd1;
                    end else begin
                        out_cnt_q <= out_cnt_q + OUT_W'(1);
                    end
                end
            end
        end
    end

    assign wr_valid_o     = wr_valid_q;
    assign wr_data_o      = wr_data_q;
    assign cw_decoded_o   = cw_decoded_q;
    assign err_overflow_o = err_overflow_q;

endmodule

// File: rtl/reed_solomon_decoder_scheduler.sv
// Paces FIFO bytes into the Reed-Solomon decoder core, limits codewords in
// flight and signals completion once the programmed job is fully decoded.
module reed_solomon_decoder_scheduler
    import reed_solomon_decoder_pkg::*;
#(
    parameter int CW_LEN       = RS_CW_LEN,
    parameter int MSG_LEN      = RS_MSG_LEN,
    parameter int GAP_CYCLES   = 12,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hc_control,
    input  logic [31:0] num_codewords,
    input  logic        fifo_not_empty,
    input  logic [7:0]  fifo_deq_data,
    output logic        fifo_deq_en,
    output logic [7:0]  dec_data,
    output logic        dec_valid,
    input  logic [7:0]  dec_data_in,
    input  logic        dec_valid_in,
    output logic [7:0]  wr_data,
    output logic        wr_valid,
    output logic [31:0] cw_started,
    output logic [31:0] cw_decoded,
    output logic        busy,
    output logic        done,
    output logic        err_overflow
);

    localparam int SYM_W = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    t_sched_state     state_q;
    logic [31:0]      total_q;
    logic [31:0]      cw_started_q;
    logic [SYM_W-1:0] sym_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [7:0]       dec_data_q;
    logic             dec_valid_q;

    logic [31:0]      inflight;
    logic             all_issued;
    logic             credit_block;
    logic             issue;

    // Wraps modulo 2^32 so the credit check stays correct across counter rollover.
    assign inflight     = cw_started_q - cw_decoded;
    assign all_issued   = (cw_started_q == total_q) && (sym_cnt_q == '0);
    assign credit_block = (sym_cnt_q == '0) && (inflight >= 32'(MAX_INFLIGHT));
    assign issue        = !reset && (state_q == S_FEED) && !all_issued
                          && !credit_block && fifo_not_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            total_q      <= '0;
            cw_started_q <= '0;
            sym_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dec_data_q   <= '0;
            dec_valid_q  <= 1'b0;
        end else begin
            dec_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hc_control == HC_CONTROL_START) begin
                        total_q <= num_codewords;
                        state_q <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (all_issued) begin
                        state_q <= S_DRAIN;
                    end else if (credit_block) begin
                        state_q <= S_STALL;
                    end else if (issue) begin
                        dec_data_q  <= fifo_deq_data;
                        dec_valid_q <= 1'b1;
                        if (sym_cnt_q == '0) begin
                            cw_started_q <= cw_started_q + 32'd1;
                        end
                        if (sym_cnt_q == SYM_W'(CW_LEN - 1)) begin
                            sym_cnt_q <= '0;
                        end else begin
                            sym_cnt_q <= sym_cnt_q + SYM_W'(1);
                        end
                        if (GAP_CYCLES != 0) begin
                            gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_FEED;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                S_STALL: begin
                    if (inflight < 32'(MAX_INFLIGHT)) begin
                        state_q <= S_FEED;
                    end
                end
                S_DRAIN: begin
                    if (cw_decoded == total_q) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    reed_solomon_decoder_out_tracker #(
        .MSG_LEN(MSG_LEN)
    ) u_out_tracker (
        .clk           (clk),
        .reset         (reset),
        .dec_valid_i   (dec_valid_in),
        .dec_data_i    (dec_data_in),
        .cw_started_i  (cw_started_q),
        .wr_valid_o    (wr_valid),
        .wr_data_o     (wr_data),
        .cw_decoded_o  (cw_decoded),
        .err_overflow_o(err_overflow)
    );

    assign fifo_deq_en = issue;
    assign dec_data    = dec_data_q;
    assign dec_valid   = dec_valid_q;
    assign cw_started  = cw_started_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);

endmodule
